vga_box_scheduler: RTL and testbench

//  Per-frame controller for the box-overlay pixel path of the 640x480 VGA display.

---
 rtl/vga_box_scheduler.sv | 152 +++++++++++++++
 tb/tb_vga_box_scheduler.sv | 139 +++++++++++++
 2 files changed

// File: rtl/vga_box_scheduler.sv
// vga_box_scheduler: per-frame box-overlay controller that shadows host writes and commits them at frame start
//  clk_sys, reset_n (sync, active-low), frame_start pulse from the VGA timing counters
//  cfg_valid/cfg_ready/cfg_addr/cfg_data: host register port (X,Y,W,H,DX,DY,COLOR,CTRL)
//  box_x/y_start/end, box_r/g/b, box_en: committed box window, stable for the whole frame
//  frame_done: pulse when box_* update; overrun: sticky frame_start-while-busy flag
module vga_box_scheduler #(
  parameter int H_DISPLAY = 640,
  parameter int V_DISPLAY = 480,
  parameter int INIT_X    = 200,
  parameter int INIT_Y    = 150,
  parameter int INIT_W    = 200,
  parameter int INIT_H    = 150
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        frame_start,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [2:0]  cfg_addr,
  input  logic [17:0] cfg_data,
  output logic [9:0]  box_x_start,
  output logic [9:0]  box_x_end,
  output logic [9:0]  box_y_start,
  output logic [9:0]  box_y_end,
  output logic [5:0]  box_r,
  output logic [5:0]  box_g,
  output logic [5:0]  box_b,
  output logic        box_en,
  output logic        frame_done,
  output logic        overrun
);
  typedef enum logic [2:0] {IDLE, LOAD, MOVE_X, MOVE_Y, COMMIT} state_t;
  typedef struct packed {
    logic [9:0]  x, y, w, h;
    logic [3:0]  dx, dy;
    logic [17:0] col;
    logic        en, mv;
  } box_t;
  typedef struct packed {
    logic [9:0]  xs, xe, ys, ye;
    logic [17:0] col;
    logic        en;
  } out_t;
  localparam box_t BOX_RST = '{x: 10'(INIT_X), y: 10'(INIT_Y), w: 10'(INIT_W), h: 10'(INIT_H),
                               dx: 4'd0, dy: 4'd0, col: 18'h3FFFF, en: 1'b1, mv: 1'b0};
  localparam out_t OUT_RST = '{xs: 10'(INIT_X), xe: 10'(INIT_X + INIT_W),
                               ys: 10'(INIT_Y), ye: 10'(INIT_Y + INIT_H),
                               col: 18'h3FFFF, en: 1'b1};
  state_t state_q, state_d;
  logic   dirty_q, dirty_d, frame_done_q, frame_done_d, overrun_q, overrun_d;
  box_t   sh_q, sh_d, wk_q, wk_d, src, ld;
  out_t   out_q, out_d;
  logic [9:0] cw, ch;
  // Returns {position, velocity} after one step; n is 12-bit so a negative step shows up in n[11].
  // -(-8) does not fit in 4 bits, so that case saturates to +7.
  function automatic logic [13:0] bounce(input logic [9:0] p, input logic [3:0] v,
                                         input logic [9:0] sz, input logic [11:0] lim);
    logic [11:0] n;
    logic [3:0]  vn;
    n  = {2'b00, p} + {{8{v[3]}}, v};
    vn = (v == 4'b1000) ? 4'd7 : 4'(-v);
    bounce = n[11] ? {10'd0, vn}
           : (n + {2'b00, sz} > lim) ? {10'(lim - {2'b00, sz}), vn}
           : {n[9:0], v};
  endfunction
  assign cfg_ready = (state_q == IDLE);
  // Frame load: take shadow only when the host wrote something, then clamp size and pull the box on-screen.
  always_comb begin
    src  = dirty_q ? sh_q : wk_q;
    cw   = (src.w > 10'(H_DISPLAY)) ? 10'(H_DISPLAY) : src.w;
    ch   = (src.h > 10'(V_DISPLAY)) ? 10'(V_DISPLAY) : src.h;
    ld   = src;
    ld.w = cw;
    ld.h = ch;
    ld.x = ({1'b0, src.x} + {1'b0, cw} > 11'(H_DISPLAY)) ? 10'(H_DISPLAY) - cw : src.x;
    ld.y = ({1'b0, src.y} + {1'b0, ch} > 11'(V_DISPLAY)) ? 10'(V_DISPLAY) - ch : src.y;
  end
  always_comb begin
    state_d      = state_q;
    dirty_d      = dirty_q;
    sh_d         = sh_q;
    wk_d         = wk_q;
    out_d        = out_q;
    frame_done_d = 1'b0;
    overrun_d    = overrun_q | (frame_start && state_q != IDLE);
    if (cfg_valid && cfg_ready) begin
      dirty_d = 1'b1;
      case (cfg_addr)
        3'd0:    sh_d.x   = cfg_data[9:0];
        3'd1:    sh_d.y   = cfg_data[9:0];
        3'd2:    sh_d.w   = cfg_data[9:0];
        3'd3:    sh_d.h   = cfg_data[9:0];
        3'd4:    sh_d.dx  = cfg_data[3:0];
        3'd5:    sh_d.dy  = cfg_data[3:0];
        3'd6:    sh_d.col = cfg_data;
        default: {sh_d.mv, sh_d.en} = cfg_data[1:0];
      endcase
    end
    case (state_q)
      IDLE:    state_d = frame_start ? LOAD : IDLE;
      LOAD: begin
        wk_d    = ld;
        dirty_d = 1'b0;
        state_d = MOVE_X;
      end
      MOVE_X: begin
        if (wk_q.mv) {wk_d.x, wk_d.dx} = bounce(wk_q.x, wk_q.dx, wk_q.w, 12'(H_DISPLAY));
        state_d = MOVE_Y;
      end
      MOVE_Y: begin
        if (wk_q.mv) {wk_d.y, wk_d.dy} = bounce(wk_q.y, wk_q.dy, wk_q.h, 12'(V_DISPLAY));
        state_d = COMMIT;
      end
      COMMIT: begin
        out_d        = '{xs: wk_q.x, xe: wk_q.x + wk_q.w, ys: wk_q.y, ye: wk_q.y + wk_q.h,
                         col: wk_q.col, en: wk_q.en};
        frame_done_d = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      dirty_q      <= 1'b0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
      sh_q         <= BOX_RST;
      wk_q         <= BOX_RST;
      out_q        <= OUT_RST;
    end else begin
      state_q      <= state_d;
      dirty_q      <= dirty_d;
      frame_done_q <= frame_done_d;
      overrun_q    <= overrun_d;
      sh_q         <= sh_d;
      wk_q         <= wk_d;
      out_q        <= out_d;
    end
  end
  assign box_x_start = out_q.xs;
  assign box_x_end   = out_q.xe;
  assign box_y_start = out_q.ys;
  assign box_y_end   = out_q.ye;
  assign box_r       = out_q.col[17:12];
  assign box_g       = out_q.col[11:6];
  assign box_b       = out_q.col[5:0];
  assign box_en      = out_q.en;
  assign frame_done  = frame_done_q;
  assign overrun     = overrun_q;
endmodule

// File: tb/tb_vga_box_scheduler.sv
// tb_vga_box_scheduler: directed scoreboard bench for vga_box_scheduler
module tb_vga_box_scheduler;
  logic        clk_sys = 1'b0;
  logic        reset_n, frame_start, cfg_valid, cfg_ready;
  logic [2:0]  cfg_addr;
  logic [17:0] cfg_data;
  logic [9:0]  box_x_start, box_x_end, box_y_start, box_y_end;
  logic [5:0]  box_r, box_g, box_b;
  logic        box_en, frame_done, overrun;
  int checks = 0, errors = 0;
  typedef struct packed {
    logic [9:0] xs, xe, ys, ye;
    logic [5:0] r, g, b;
    logic       en;
  } exp_t;
  exp_t q[$];
  vga_box_scheduler dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .frame_start(frame_start),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .box_x_start(box_x_start), .box_x_end(box_x_end), .box_y_start(box_y_start), .box_y_end(box_y_end),
    .box_r(box_r), .box_g(box_g), .box_b(box_b), .box_en(box_en),
    .frame_done(frame_done), .overrun(overrun)
  );
  always #5 clk_sys = ~clk_sys;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  function automatic exp_t mk(input int xs, xe, ys, ye, r, g, b, en);
    mk = '{xs: 10'(xs), xe: 10'(xe), ys: 10'(ys), ye: 10'(ye), r: 6'(r), g: 6'(g), b: 6'(b), en: 1'(en)};
  endfunction
  task automatic chk_out(input string tag, input exp_t e);
    chk({tag, " x_start"}, 32'(box_x_start), 32'(e.xs));
    chk({tag, " x_end"},   32'(box_x_end),   32'(e.xe));
    chk({tag, " y_start"}, 32'(box_y_start), 32'(e.ys));
    chk({tag, " y_end"},   32'(box_y_end),   32'(e.ye));
    chk({tag, " r"},       32'(box_r),       32'(e.r));
    chk({tag, " g"},       32'(box_g),       32'(e.g));
    chk({tag, " b"},       32'(box_b),       32'(e.b));
    chk({tag, " en"},      32'(box_en),      32'(e.en));
  endtask
  // Monitor: every frame_done pulse must match the oldest expected frame.
  always @(negedge clk_sys) begin
    if (frame_done) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected frame_done: got 1 expected 0 (no frame pending)");
      end else chk_out("frame", q.pop_front());
    end
  end
  task automatic wr(input logic [2:0] a, input logic [17:0] d);
    @(negedge clk_sys);
    chk("cfg_ready idle", 32'(cfg_ready), 1);
    cfg_valid = 1'b1;
    cfg_addr  = a;
    cfg_data  = d;
    @(negedge clk_sys);
    cfg_valid = 1'b0;
  endtask
  // Issues one frame_start; optionally a second one sampled two edges later.
  task automatic frame(input exp_t e, input bit dbl);
    logic [9:0] old_x;
    @(negedge clk_sys);
    old_x = box_x_start;
    q.push_back(e);
    frame_start = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_sys);
      frame_start = (k == 0) && dbl;
      chk("busy cfg_ready", 32'(cfg_ready), 0);
      chk("early frame_done", 32'(frame_done), 0);
      chk("x held before commit", 32'(box_x_start), 32'(old_x));
    end
    @(negedge clk_sys);
    chk("frame_done at T+4", 32'(frame_done), 1);
    chk("cfg_ready after commit", 32'(cfg_ready), 1);
    @(negedge clk_sys);
    chk("frame_done single pulse", 32'(frame_done), 0);
  endtask
  initial begin
    exp_t rst_e;
    rst_e = mk(200, 400, 150, 300, 63, 63, 63, 1);
    reset_n = 1'b0; frame_start = 1'b0; cfg_valid = 1'b0; cfg_addr = '0; cfg_data = '0;
    repeat (3) @(negedge clk_sys);
    chk_out("reset", rst_e);
    chk("reset frame_done", 32'(frame_done), 0);
    chk("reset overrun", 32'(overrun), 0);
    chk("reset cfg_ready", 32'(cfg_ready), 1);
    reset_n = 1'b1;
    frame(rst_e, 1'b0);
    wr(3'd0, 18'd50);
    wr(3'd6, 18'h3F000);
    frame(mk(50, 250, 150, 300, 63, 0, 0, 1), 1'b0);
    wr(3'd7, 18'd3);
    wr(3'd4, 18'd7);
    wr(3'd0, 18'd435);
    wr(3'd2, 18'd200);
    frame(mk(440, 640, 150, 300, 63, 0, 0, 1), 1'b0);
    frame(mk(433, 633, 150, 300, 63, 0, 0, 1), 1'b0);
    wr(3'd5, 18'h8);
    wr(3'd1, 18'd5);
    wr(3'd7, 18'd3);
    frame(mk(440, 640, 0, 150, 63, 0, 0, 1), 1'b0);
    frame(mk(433, 633, 7, 157, 63, 0, 0, 1), 1'b0);
    chk("overrun before double", 32'(overrun), 0);
    frame(mk(426, 626, 14, 164, 63, 0, 0, 1), 1'b1);
    chk("overrun after double", 32'(overrun), 1);
    wr(3'd2, 18'd700);
    wr(3'd3, 18'd0);
    wr(3'd0, 18'd100);
    wr(3'd7, 18'd0);
    frame(mk(0, 640, 5, 5, 63, 0, 0, 0), 1'b0);
    chk("overrun sticky", 32'(overrun), 1);
    wr(3'd6, 18'h00FC0);
    wr(3'd0, 18'd300);
    @(negedge clk_sys);
    frame_start = 1'b1;
    @(negedge clk_sys);
    frame_start = 1'b0;
    @(negedge clk_sys);
    @(negedge clk_sys);
    reset_n = 1'b0;
    repeat (2) @(negedge clk_sys);
    chk_out("abort reset", rst_e);
    chk("abort overrun cleared", 32'(overrun), 0);
    reset_n = 1'b1;
    repeat (6) @(negedge clk_sys);
    chk("abort no commit x", 32'(box_x_start), 200);
    frame(rst_e, 1'b0);
    repeat (3) @(negedge clk_sys);
    chk("scoreboard drained", 32'(q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
